// File: rtl/ins_fetch.sv
// Instruction fetch/sequencer with a 32x20 program store feeding the cpum datapath.
// Optional single-step control is enabled by defining INS_FETCH_STEP_EN.
module ins_fetch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_en,
  input  logic [4:0]  load_addr,
  input  logic [19:0] load_data,
  input  logic        run,
  input  logic        zf,
  input  logic        sf,
`ifdef INS_FETCH_STEP_EN
  input  logic        step,
`endif
  output logic [19:0] ins,
  output logic [4:0]  pc,
  output logic        busy,
  output logic        halted
);

  typedef enum logic [1:0] {IDLE, RUN, WAIT, HALT} state_t;

  state_t      state;
  logic [19:0] mem [32];
  logic [4:0]  tgt;
  logic        cond_z;
  logic [19:0] w;
  logic [3:0]  op;
  logic [4:0]  pc_inc;
  logic        adv;
  logic        cond;

  assign w      = mem[pc];
  assign op     = w[19:16];
  assign pc_inc = pc + 5'd1;
  assign cond   = cond_z ? zf : sf;

`ifdef INS_FETCH_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  // Store has no reset so a program survives rst_n; writes only while not executing.
  always_ff @(posedge clk) begin
    if (rst_n && load_en && (state == IDLE || state == HALT))
      mem[load_addr] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc     <= '0;
      ins    <= '0;
      busy   <= 1'b0;
      halted <= 1'b0;
      tgt    <= '0;
      cond_z <= 1'b0;
    end else begin
      ins <= '0;
      case (state)
        IDLE, HALT: begin
          if (!load_en && run) begin
            pc     <= '0;
            state  <= RUN;
            busy   <= 1'b1;
            halted <= 1'b0;
          end
        end
        RUN: begin
          if (adv) begin
            case (op)
              4'hF: begin
                state  <= HALT;
                busy   <= 1'b0;
                halted <= 1'b1;
              end
              4'hE: pc <= w[4:0];
              4'hD, 4'hC: begin
                tgt    <= w[4:0];
                cond_z <= (op == 4'hD);
                state  <= WAIT;
              end
              default: begin
                ins <= w;
                pc  <= pc_inc;
              end
            endcase
          end
        end
        WAIT: begin
          // Flags are sampled here, one bubble after the branch was decoded.
          if (adv) begin
            pc    <= cond ? tgt : pc_inc;
            state <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
